// File: rtl/fbu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fbu_pkg
//  Description : Opcodes and instruction field positions for the fetch /
//                branch-resolution front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package fbu_pkg;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_BLEZ = 6'h06;
    localparam logic [5:0] OP_BGTZ = 6'h07;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int IMM16_HI = 15;
    localparam int IMM26_HI = 25;

    function automatic logic is_jump(input logic [5:0] opcode);
        return (opcode == OP_J) || (opcode == OP_JAL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve
//  Description : Combinational branch/jump condition and target computation.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
    import fbu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [5:0]        opcode,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       rt_data,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [15:0]       imm16,
    input  logic [25:0]       imm26,
    output logic              taken,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] w_pc_plus1;
    logic [31:0]       w_imm_ext;
    logic [ADDR_W-1:0] w_branch_target;
    logic [ADDR_W-1:0] w_jump_target;

    assign w_pc_plus1      = id_pc + ADDR_W'(1);
    assign w_imm_ext       = {{16{imm16[15]}}, imm16};
    assign w_branch_target = w_pc_plus1 + w_imm_ext[ADDR_W-1:0];

    // Narrow address spaces take the jump field directly; wide ones keep the upper PC bits.
    generate
        if (ADDR_W > 26) begin : g_jump_wide
            assign w_jump_target = {w_pc_plus1[ADDR_W-1:26], imm26};
        end else begin : g_jump_narrow
            assign w_jump_target = imm26[ADDR_W-1:0];
        end
    endgenerate

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_J, OP_JAL: taken = 1'b1;
            OP_BEQ:       taken = (rs_data == rt_data);
            OP_BNE:       taken = (rs_data != rt_data);
            OP_BLEZ:      taken = ($signed(rs_data) <= 32'sd0);
            OP_BGTZ:      taken = ($signed(rs_data) > 32'sd0);
            default:      taken = 1'b0;
        endcase
    end

    assign target = is_jump(opcode) ? w_jump_target : w_branch_target;

endmodule
`default_nettype wire

// File: rtl/fetch_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_branch_unit
//  Description : PC, instruction fetch, one decode stage and decode-time
//                branch/jump resolution with optional delay slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_branch_unit
    import fbu_pkg::*;
#(
    parameter int          ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int          BR_DELAY_SLOT = 0,
    parameter int          CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       rt_data,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_target,
    output logic [CNT_W-1:0]  taken_count
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_id_valid;
    logic [31:0]       r_id_instr;
    logic [ADDR_W-1:0] r_id_pc;
    logic [CNT_W-1:0]  r_taken_count;

    logic              w_cond;
    logic              w_taken;
    logic [ADDR_W-1:0] w_target;

    branch_resolve #(
        .ADDR_W (ADDR_W)
    ) u_branch_resolve (
        .opcode  (r_id_instr[OPC_HI:OPC_LO]),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .id_pc   (r_id_pc),
        .imm16   (r_id_instr[IMM16_HI:0]),
        .imm26   (r_id_instr[IMM26_HI:0]),
        .taken   (w_cond),
        .target  (w_target)
    );

    assign w_taken = r_id_valid & w_cond;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_id_valid    <= 1'b0;
            r_id_instr    <= '0;
            r_id_pc       <= '0;
            r_taken_count <= '0;
        end else if (!stall) begin
            r_id_instr <= imem_rdata;
            r_id_pc    <= r_pc;
            if (w_taken) begin
                r_pc       <= w_target;
                // The wrong-path fetch is kept only when the ISA defines a delay slot.
                r_id_valid <= (BR_DELAY_SLOT != 0);
                if (r_taken_count != {CNT_W{1'b1}}) begin
                    r_taken_count <= r_taken_count + CNT_W'(1);
                end
            end else begin
                r_pc       <= r_pc + ADDR_W'(1);
                r_id_valid <= 1'b1;
            end
        end
    end

    assign imem_addr       = r_pc;
    assign rs_addr         = r_id_instr[RS_HI:RS_LO];
    assign rt_addr         = r_id_instr[RT_HI:RT_LO];
    assign id_valid        = r_id_valid;
    assign id_instr        = r_id_instr;
    assign id_pc           = r_id_pc;
    assign redirect        = w_taken & ~stall;
    assign redirect_target = w_target;
    assign taken_count     = r_taken_count;

endmodule
`default_nettype wire

// File: doc/fetch_branch_unit.md
# fetch_branch_unit

Parametrised fetch and branch-resolution front end. Holds the program counter, fetches from instruction memory, and registers one decode stage. It resolves conditional branches and jumps in decode, redirects the PC, and optionally squashes the wrong-path instruction. It sits between instruction memory and the register file / execute pipeline, and replaces the hand-wired PC, delay-flop, branch-adder and branch-mux chain.

## Interface
Parameters:
- ADDR_W, 32: PC / instruction address width in words; legal range 16..32.
- RESET_PC, 0: PC value loaded on reset.
- BR_DELAY_SLOT, 0: 1 = instruction after a taken branch/jump executes (not squashed); 0 = it is squashed.
- CNT_W, 16: width of the taken-transfer counter.

Ports (the single clock and the reset are the only timing inputs; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold the PC and the decode stage.
- imem_addr  out  ADDR_W  word address to instruction memory; equals the PC register.
- imem_rdata  in  32  instruction at imem_addr, same cycle (asynchronous read).
- rs_addr  out  5  id_instr[25:21], to register file read port 1.
- rt_addr  out  5  id_instr[20:16], to register file read port 2.
- rs_data  in  32  register file read data for rs_addr, same cycle.
- rt_data  in  32  register file read data for rt_addr, same cycle.
- id_valid  out  1  decode stage holds a live instruction.
- id_instr  out  32  decode-stage instruction.
- id_pc  out  ADDR_W  address of id_instr.
- redirect  out  1  a taken transfer is resolving this cycle.
- redirect_target  out  ADDR_W  next PC when redirect is high.
- taken_count  out  CNT_W  saturating count of taken transfers.

## Operation
- Decoded opcodes, from id_instr[31:26]:
  - J = 02, JAL = 03: always taken.
  - BEQ = 04: taken when rs_data == rt_data.
  - BNE = 05: taken when rs_data != rt_data.
  - BLEZ = 06: taken when $signed(rs_data) <= 0.
  - BGTZ = 07: taken when $signed(rs_data) > 0.
  - All other opcodes are never taken.
- JAL handling: the link write is performed downstream, using id_pc.
- taken = id_valid & opcode condition.
- redirect = taken & ~stall.
- Branch target: id_pc + 1 + sign_extend(id_instr[15:0]), truncated to ADDR_W (modulo 2^ADDR_W).
- Jump target:
  - ADDR_W > 26: {(id_pc+1)[ADDR_W-1:26], id_instr[25:0]}.
  - Otherwise: id_instr[ADDR_W-1:0].
- Sequential update, in priority order:
  - reset: pc = RESET_PC; id_valid = 0; id_instr = 0; id_pc = 0; taken_count = 0.
  - stall: all registers hold.
  - redirect:
    - pc = redirect_target.
    - id_instr = imem_rdata; id_pc = pc.
    - id_valid = BR_DELAY_SLOT ? 1 : 0.
    - taken_count += 1, saturating at all-ones.
  - otherwise: pc = pc + 1 (wraps at 2^ADDR_W); id_instr = imem_rdata; id_pc = pc; id_valid = 1.
- With BR_DELAY_SLOT = 1, a transfer sitting in the delay slot is resolved normally on its own decode cycle.

## Timing
- Fetch-to-decode latency: 1 cycle.
- After reset deasserts:
  - Cycle 0: imem_addr = RESET_PC, id_valid = 0.
  - Cycle 1: id_pc = RESET_PC, id_valid = 1.
- Taken-transfer penalty: 1 bubble cycle when BR_DELAY_SLOT = 0; 0 bubbles when BR_DELAY_SLOT = 1.
- redirect and redirect_target are combinational from the decode registers and rs_data / rt_data. rs_data and rt_data must be stable before the clock edge.
- stall together with a taken transfer: stall wins. The transfer stays in decode and redirects on the first cycle stall is low. taken_count increments exactly once.
- Reset mid-transfer: reset overrides everything. No redirect is recorded.

## Structure
- Shared package fbu_pkg:
  - Opcode localparams (OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ).
  - Field bit positions (opcode, rs, rt, imm16, imm26).
- One combinational sub-module, branch_resolve:
  - Inputs: opcode, rs_data, rt_data, id_pc, immediates.
  - Outputs: taken and target.
- fetch_branch_unit owns all registers and the counter.

## Test plan
- No transfers: reset, then imem_rdata = 0 (NOP) for 5 cycles → imem_addr 0,1,2,3,4; id_valid 0,1,1,1,1; id_pc lags imem_addr by 1; taken_count = 0.
- BEQ taken, BR_DELAY_SLOT = 0:
  - Stimulus: BEQ at 4 with imm = +3, rs_data = rt_data = 7.
  - Response: redirect = 1 with target 8; the instruction fetched at 5 arrives with id_valid = 0; next id_pc = 8; taken_count = 1.
- BNE not taken, BLEZ negative wrap:
  - BNE at 2 with rs_data = rt_data → no redirect.
  - BLEZ at 2 with imm = 0xFFFB, rs_data = 0 → target 0xFFFFFFFE (ADDR_W = 32).
- J with ADDR_W = 32:
  - Stimulus: J at 0x10 with imm26 = 0x40.
  - Response: redirect_target = 0x40; imem_addr = 0x40 on the next cycle.
  - Repeat with id_pc = 0x0C000010 → target 0x0C000040.
- Stall during BEQ taken:
  - Stimulus: stall high for 3 cycles while the BEQ is in decode.
  - Response: imem_addr, id_pc and taken_count hold; redirect = 0 while stalled; redirect on the cycle stall drops; taken_count rises by exactly 1.
- BR_DELAY_SLOT = 1:
  - Stimulus: BEQ at 4, imm = +3, taken.
  - Response: id_pc sequence 4, 5 (id_valid = 1), 8.
  - Also: 2^CNT_W + 2 taken jumps with CNT_W = 4 → taken_count holds at 15.
